serial_to_parallel_rx: RTL and testbench

- Receive side of the team's serial bit-stream link, matching the right-shift transmitter that sends LSB first.
- Gathers WORD_LENGTH bits, strobed one per shift pulse, into a parallel word and hands it to the consumer with a valid/ack handshake.
- Reports frame progress and overruns.
- Sits between the serial link pins/logic and the word-level datapath.

---
 rtl/serial_to_parallel_rx.sv | 97 +++++++++
 tb/tb_serial_to_parallel_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_rx.sv
// LSB-first serial receiver: gathers WORD_LENGTH strobed bits into a word and
// presents it to the consumer through a valid/ack handshake with overrun flagging.
module serial_to_parallel_rx #(
  parameter int WORD_LENGTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               shift,
  input  logic                               serialInput,
  input  logic                               dataAck,
  output logic [WORD_LENGTH-1:0]             parallelOutput,
  output logic                               dataValid,
  output logic                               busy,
  output logic [$clog2(WORD_LENGTH+1)-1:0]   bitCount,
  output logic                               overrun
);

  localparam int CW = $clog2(WORD_LENGTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_LENGTH - 1);

  typedef enum logic {IDLE = 1'b0, RECEIVE = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [WORD_LENGTH-1:0] r_shift;
  logic [CW-1:0]          r_bit_count;
  logic [WORD_LENGTH-1:0] r_parallel;
  logic                   r_valid;
  logic                   r_overrun;

  logic                   w_capture;
  logic                   w_complete;
  logic [WORD_LENGTH-1:0] w_word;

  // start has priority over a coincident strobe, so that bit is never captured
  assign w_capture  = (r_state == RECEIVE) && shift && !start;
  assign w_complete = w_capture && (r_bit_count == LAST_BIT);
  assign w_word     = {serialInput, r_shift[WORD_LENGTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = RECEIVE;
    end else if (w_complete) begin
      w_state_next = IDLE;
    end
  end

  always_comb begin
    busy = (r_state == RECEIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift     <= '0;
      r_bit_count <= '0;
    end else if (start) begin
      r_bit_count <= '0;
    end else if (w_capture) begin
      r_shift     <= w_word;
      r_bit_count <= w_complete ? '0 : r_bit_count + 1'b1;
    end
  end

  // A finished word only replaces the output if the previous one is gone or leaving now
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parallel <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_complete) begin
      if (!r_valid || dataAck) begin
        r_parallel <= w_word;
        r_valid    <= 1'b1;
      end else begin
        r_overrun  <= 1'b1;
      end
    end else if (r_valid && dataAck) begin
      r_valid <= 1'b0;
    end
  end

  assign parallelOutput = r_parallel;
  assign dataValid      = r_valid;
  assign bitCount       = r_bit_count;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx: frames, gaps, handshake, overrun,
// restart and mid-frame reset, each checked against hand-computed values.
module tb_serial_to_parallel_rx;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          shift;
  logic          serialInput;
  logic          dataAck;
  logic [W-1:0]  parallelOutput;
  logic          dataValid;
  logic          busy;
  logic [CW-1:0] bitCount;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  serial_to_parallel_rx #(.WORD_LENGTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .shift         (shift),
    .serialInput   (serialInput),
    .dataAck       (dataAck),
    .parallelOutput(parallelOutput),
    .dataValid     (dataValid),
    .busy          (busy),
    .bitCount      (bitCount),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends w LSB first; gapped mode inserts i%4 idle cycles after strobe i.
  task automatic send_frame(input logic [W-1:0] w, input bit gapped, input bit ack_last,
                            input bit chk_cnt);
    for (int i = 0; i < W; i++) begin
      shift       = 1'b1;
      serialInput = w[i];
      dataAck     = (ack_last && i == W - 1);
      tick();
      shift   = 1'b0;
      dataAck = 1'b0;
      if (i < W - 1) begin
        if (chk_cnt) check("bitcount_strobe", 32'(bitCount), 32'(i + 1));
        if (gapped) begin
          for (int g = 0; g < i % 4; g++) begin
            tick();
            if (chk_cnt) check("bitcount_gap", 32'(bitCount), 32'(i + 1));
          end
        end
      end
    end
    $display("frame sent %02h -> out=%02h valid=%0b overrun=%0b", w, parallelOutput, dataValid,
             overrun);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic ack_once();
    dataAck = 1'b1;
    tick();
    dataAck = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out"},     32'(parallelOutput), 32'h0);
    check({tag, "_valid"},   32'(dataValid),      32'h0);
    check({tag, "_busy"},    32'(busy),           32'h0);
    check({tag, "_bitcnt"},  32'(bitCount),       32'h0);
    check({tag, "_overrun"}, 32'(overrun),        32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; shift = 1'b0; serialInput = 1'b0; dataAck = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_all_zero("reset");

    // basic frame
    pulse_start();
    check("start_busy", 32'(busy), 32'h1);
    check("start_bitcnt", 32'(bitCount), 32'h0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check("basic_out", 32'(parallelOutput), 32'hA5);
    check("basic_valid", 32'(dataValid), 32'h1);
    check("basic_busy", 32'(busy), 32'h0);
    check("basic_bitcnt", 32'(bitCount), 32'h0);

    // ack clears valid, output held
    ack_once();
    check("ack_valid", 32'(dataValid), 32'h0);
    check("ack_out", 32'(parallelOutput), 32'hA5);

    // shifts in IDLE are ignored
    shift = 1'b1; serialInput = 1'b1;
    tick(); tick(); tick();
    shift = 1'b0;
    check("idle_bitcnt", 32'(bitCount), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_valid", 32'(dataValid), 32'h0);
    check("idle_out", 32'(parallelOutput), 32'hA5);

    // gapped strobes
    pulse_start();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    check("gap_out", 32'(parallelOutput), 32'hA5);
    check("gap_valid", 32'(dataValid), 32'h1);
    check("gap_busy", 32'(busy), 32'h0);

    // overrun: unacked word blocks the next one
    pulse_start();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ovr_out", 32'(parallelOutput), 32'hA5);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_valid", 32'(dataValid), 32'h1);
    ack_once();
    check("ovr_ack_valid", 32'(dataValid), 32'h0);
    pulse_start();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ovr2_out", 32'(parallelOutput), 32'h3C);
    check("ovr2_valid", 32'(dataValid), 32'h1);
    check("ovr2_sticky", 32'(overrun), 32'h1);

    // simultaneous ack and completion
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst2_overrun", 32'(overrun), 32'h0);
    pulse_start();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    check("sim_first_out", 32'(parallelOutput), 32'hA5);
    pulse_start();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check("sim_out", 32'(parallelOutput), 32'h3C);
    check("sim_valid", 32'(dataValid), 32'h1);
    check("sim_overrun", 32'(overrun), 32'h0);

    // restart: start together with shift drops that bit
    ack_once();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      shift = 1'b1; serialInput = 1'b1;
      tick();
    end
    shift = 1'b0;
    check("restart_pre_bitcnt", 32'(bitCount), 32'h4);
    start = 1'b1; shift = 1'b1; serialInput = 1'b1;
    tick();
    start = 1'b0; shift = 1'b0;
    check("restart_bitcnt", 32'(bitCount), 32'h0);
    check("restart_busy", 32'(busy), 32'h1);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    check("restart_out", 32'(parallelOutput), 32'h81);
    check("restart_valid", 32'(dataValid), 32'h1);

    // reset mid-frame at bitCount=5 with an unacked word pending
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      shift = 1'b1; serialInput = 1'b1;
      tick();
    end
    shift = 1'b0;
    check("midrst_pre_bitcnt", 32'(bitCount), 32'h5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
